nibble_serial_adder: RTL

- Multi-cycle wide adder that adds WIDTH-bit operands one 4-bit nibble per clock, least-significant nibble first.
- Uses a single 4-bit full-adder slice with a registered carry between nibbles.
- Sits between the operand source and the result consumer, with valid/ready handshakes on both sides.
- Trades latency for area compared with a full-width parallel adder.

---
 rtl/nibble_serial_adder.sv | 84 ++++++++
 1 files changed

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder built from one 4-bit slice, one nibble per clock, LSB nibble first,
// with valid/ready handshakes on both the operand and result sides.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = NIB > 1 ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] opa, opb;
    logic             carry;
    logic [IW-1:0]    idx;
    logic [3:0]       na, nb;
    logic [4:0]       nsum;
    logic             last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE ? (in_valid ? ADD : IDLE) :
                   state == ADD  ? (last ? DONE : ADD) :
                                   (out_ready ? IDLE : DONE);
    end

    always_comb begin
        in_ready  = state == IDLE;
        busy      = state != IDLE;
        out_valid = state == DONE;
    end

    // Nibble mux for the current index; the full 5-bit sum keeps the carry intact.
    always_comb begin
        na = '0;
        nb = '0;
        for (int k = 0; k < NIB; k++) begin
            if (idx == IW'(k)) begin
                na = opa[4*k +: 4];
                nb = opb[4*k +: 4];
            end
        end
        nsum = {1'b0, na} + {1'b0, nb} + {4'b0, carry};
        last = idx == IW'(NIB - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            opa   <= a;
            opb   <= b;
            carry <= cin;
            idx   <= '0;
        end else if (state == ADD) begin
            carry <= nsum[4];
            idx   <= last ? '0 : idx + 1'b1;
            for (int k = 0; k < NIB; k++)
                if (idx == IW'(k)) sum[4*k +: 4] <= nsum[3:0];
            if (last) cout <= nsum[4];
        end
    end
endmodule
